// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: opcodes, sizes, the NOP
// encoding and the decode-stage bundle.
package rv32i_pkg;

  localparam int XLEN   = 32;
  localparam int NREGS  = 32;
  localparam int REG_AW = 5;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [XLEN-1:0] NOP_INST_VAL = 32'h0000_0013;

  typedef enum logic {
    S_RUN,
    S_HOLD
  } dec_state_t;

  typedef struct packed {
    logic              valid;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   inst;
    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic [XLEN-1:0]   imm;
    logic              illegal;
  } dec_t;

  function automatic dec_t dec_bubble(
    input logic [XLEN-1:0] nop
  );
    dec_t b;
    b      = '0;
    b.inst = nop;
    return b;
  endfunction

endpackage

// File: rtl/reg_file.sv
// 32x32 integer register file, two async read
// ports with write-back bypass, one write port.
module reg_file
  import rv32i_pkg::*;
(
  input  logic              CLK,
  input  logic              i_we,
  input  logic [REG_AW-1:0] i_waddr,
  input  logic [XLEN-1:0]   i_wdata,
  input  logic [REG_AW-1:0] i_raddr1,
  input  logic [REG_AW-1:0] i_raddr2,
  output logic [XLEN-1:0]   o_rdata1,
  output logic [XLEN-1:0]   o_rdata2
);

  logic [XLEN-1:0] r_mem [NREGS];
  logic            w_wr;

  assign w_wr = i_we && (i_waddr != '0);

  always_ff @(posedge CLK) begin
    if (w_wr) r_mem[i_waddr] <= i_wdata;
  end

  always_comb begin
    o_rdata1 = r_mem[i_raddr1];
    o_rdata2 = r_mem[i_raddr2];
    if (w_wr && i_waddr == i_raddr1)
      o_rdata1 = i_wdata;
    if (w_wr && i_waddr == i_raddr2)
      o_rdata2 = i_wdata;
    if (i_raddr1 == '0) o_rdata1 = '0;
    if (i_raddr2 == '0) o_rdata2 = '0;
  end

endmodule

// File: rtl/inst_decode.sv
// RV32I decode stage: field/immediate decode, operand
// read with bypass, load-use bubble insertion.
module inst_decode
  import rv32i_pkg::*;
#(
  parameter logic [XLEN-1:0] C_NOP_INST = NOP_INST_VAL
)(
  input  logic              CLK,
  input  logic              RST,
  input  logic              STALL,
  input  logic              FLUSH,
  output logic              HAZARD,
  input  logic [XLEN-1:0]   I_PC,
  input  logic [XLEN-1:0]   I_INST,
  input  logic              I_VALID,
  input  logic              WB_EN,
  input  logic [REG_AW-1:0] WB_RD,
  input  logic [XLEN-1:0]   WB_DATA,
  output logic              D_VALID,
  output logic [XLEN-1:0]   D_PC,
  output logic [XLEN-1:0]   D_INST,
  output logic [6:0]        D_OPCODE,
  output logic [2:0]        D_FUNCT3,
  output logic [6:0]        D_FUNCT7,
  output logic [REG_AW-1:0] D_RD,
  output logic [REG_AW-1:0] D_RS1,
  output logic [REG_AW-1:0] D_RS2,
  output logic [XLEN-1:0]   D_RS1_DATA,
  output logic [XLEN-1:0]   D_RS2_DATA,
  output logic [XLEN-1:0]   D_IMM,
  output logic              D_ILLEGAL
);

  dec_state_t      r_state;
  dec_t            r_d;
  dec_t            w_dec;
  dec_t            w_bub;
  logic [XLEN-1:0] r_pend_inst;
  logic [XLEN-1:0] r_pend_pc;
  logic [XLEN-1:0] w_inst;
  logic [XLEN-1:0] w_pc;
  logic [XLEN-1:0] w_imm;
  logic [XLEN-1:0] w_rs1_data;
  logic [XLEN-1:0] w_rs2_data;
  logic [6:0]      w_opc;
  logic            w_ill;
  logic            w_use1;
  logic            w_use2;
  logic            w_hit;
  logic            w_hazard;

  // In HOLD the parked instruction owns the decoder.
  always_comb begin
    w_inst = I_INST;
    w_pc   = I_PC;
    if (r_state == S_HOLD) begin
      w_inst = r_pend_inst;
      w_pc   = r_pend_pc;
    end
  end

  assign w_opc = w_inst[6:0];

  always_comb begin
    w_imm  = '0;
    w_ill  = 1'b0;
    w_use1 = 1'b1;
    w_use2 = 1'b0;
    unique case (w_opc)
      OPC_LOAD, OPC_OP_IMM, OPC_JALR:
        w_imm = {{20{w_inst[31]}}, w_inst[31:20]};
      OPC_STORE: begin
        w_imm = {{20{w_inst[31]}},
                 w_inst[31:25], w_inst[11:7]};
        w_use2 = 1'b1;
      end
      OPC_BRANCH: begin
        w_imm = {{20{w_inst[31]}}, w_inst[7],
                 w_inst[30:25], w_inst[11:8], 1'b0};
        w_use2 = 1'b1;
      end
      OPC_LUI, OPC_AUIPC: begin
        w_imm  = {w_inst[31:12], 12'b0};
        w_use1 = 1'b0;
      end
      OPC_JAL: begin
        w_imm = {{12{w_inst[31]}}, w_inst[19:12],
                 w_inst[20], w_inst[30:21], 1'b0};
        w_use1 = 1'b0;
      end
      OPC_OP:
        w_use2 = 1'b1;
      OPC_MISC_MEM, OPC_SYSTEM: ;
      default:
        w_ill = 1'b1;
    endcase
  end

  reg_file u_rf (
    .CLK      (CLK),
    .i_we     (WB_EN),
    .i_waddr  (WB_RD),
    .i_wdata  (WB_DATA),
    .i_raddr1 (w_inst[19:15]),
    .i_raddr2 (w_inst[24:20]),
    .o_rdata1 (w_rs1_data),
    .o_rdata2 (w_rs2_data)
  );

  always_comb begin
    w_dec          = '0;
    w_dec.valid    = 1'b1;
    w_dec.pc       = w_pc;
    w_dec.inst     = w_inst;
    w_dec.opcode   = w_opc;
    w_dec.funct3   = w_inst[14:12];
    w_dec.funct7   = w_inst[31:25];
    w_dec.rd       = w_inst[11:7];
    w_dec.rs1      = w_inst[19:15];
    w_dec.rs2      = w_inst[24:20];
    w_dec.rs1_data = w_rs1_data;
    w_dec.rs2_data = w_rs2_data;
    w_dec.imm      = w_imm;
    w_dec.illegal  = w_ill;
  end

  assign w_bub = dec_bubble(C_NOP_INST);

  assign w_hit =
    (w_use1 && w_inst[19:15] == r_d.rd) ||
    (w_use2 && w_inst[24:20] == r_d.rd);

  assign w_hazard = !RST && !FLUSH && !STALL &&
                    (r_state == S_RUN) && I_VALID &&
                    r_d.valid &&
                    (r_d.opcode == OPC_LOAD) &&
                    (r_d.rd != '0) && w_hit;

  assign HAZARD = w_hazard;

  always_ff @(posedge CLK) begin
    if (RST || FLUSH) begin
      r_d         <= w_bub;
      r_state     <= S_RUN;
      r_pend_inst <= '0;
      r_pend_pc   <= '0;
    end else if (!STALL) begin
      unique case (r_state)
        S_HOLD: begin
          r_d     <= w_dec;
          r_state <= S_RUN;
        end
        default: begin
          if (w_hazard) begin
            r_d         <= w_bub;
            r_pend_inst <= I_INST;
            r_pend_pc   <= I_PC;
            r_state     <= S_HOLD;
          end else if (I_VALID) begin
            r_d <= w_dec;
          end else begin
            r_d <= w_bub;
          end
        end
      endcase
    end
  end

  assign D_VALID    = r_d.valid;
  assign D_PC       = r_d.pc;
  assign D_INST     = r_d.inst;
  assign D_OPCODE   = r_d.opcode;
  assign D_FUNCT3   = r_d.funct3;
  assign D_FUNCT7   = r_d.funct7;
  assign D_RD       = r_d.rd;
  assign D_RS1      = r_d.rs1;
  assign D_RS2      = r_d.rs2;
  assign D_RS1_DATA = r_d.rs1_data;
  assign D_RS2_DATA = r_d.rs2_data;
  assign D_IMM      = r_d.imm;
  assign D_ILLEGAL  = r_d.illegal;

endmodule
